// File: rtl/execute_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_unit_if : uop encoding and execute-stage request/response bundle   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package Utilities;
  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    ORR = 4'd4,
    EOR = 4'd5,
    MOV = 4'd6,
    CMP = 4'd7,
    MUL = 4'd8,
    STR = 4'd9
  } Uop;
endpackage

interface execute_unit_if;
  logic          start;
  Utilities::Uop uop;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [3:0]    sel_dest;
  logic [3:0]    flags_in;
  logic [31:0]   result;
  logic [3:0]    flags_out;
  logic [3:0]    sel_out;
  Utilities::Uop uop_out;
  logic          done;
  logic          busy;
  logic          rf_not_enable;

  modport master (
    output start, uop, op_a, op_b, sel_dest, flags_in,
    input  result, flags_out, sel_out, uop_out, done, busy, rf_not_enable
  );

  modport slave (
    input  start, uop, op_a, op_b, sel_dest, flags_in,
    output result, flags_out, sel_out, uop_out, done, busy, rf_not_enable
  );
endinterface
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_unit : single-cycle ALU with NZCV flags and iterative shift-add MUL |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module execute_unit #(
  parameter int MUL_BITS = 1
) (
  input  wire logic     clock,
  input  wire logic     not_reset,
  execute_unit_if.slave bus
);
  import Utilities::*;

  localparam int         ITER       = 32 / MUL_BITS;
  localparam logic [4:0] c_last_cnt = 5'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [31:0] result_q,  result_d;
  logic [3:0]  flags_q,   flags_d;
  logic [3:0]  sel_q,     sel_d;
  Uop          uop_q,     uop_d;
  logic [31:0] mcand_q,   mcand_d;
  logic [31:0] mplier_q,  mplier_d;
  logic [31:0] acc_q,     acc_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic [3:0]  mul_sel_q, mul_sel_d;
  logic [1:0]  mul_cv_q,  mul_cv_d;

  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [31:0] w_alu_res;
  logic        w_alu_c;
  logic        w_alu_v;
  logic        w_alu_pass;
  logic [3:0]  w_alu_flags;
  logic [31:0] w_pp [MUL_BITS];
  logic [31:0] w_acc_next;

  assign w_add = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign w_sub = {1'b0, bus.op_a} - {1'b0, bus.op_b};

  always_comb begin
    w_alu_res  = bus.op_b;
    w_alu_c    = bus.flags_in[1];
    w_alu_v    = bus.flags_in[0];
    w_alu_pass = 1'b0;
    case (bus.uop)
      ADD: begin
        w_alu_res = w_add[31:0];
        w_alu_c   = w_add[32];
        w_alu_v   = (bus.op_a[31] == bus.op_b[31]) && (w_add[31] != bus.op_a[31]);
      end
      SUB, CMP: begin
        // w_sub[32] is the borrow; carry is its inverse
        w_alu_res = w_sub[31:0];
        w_alu_c   = ~w_sub[32];
        w_alu_v   = (bus.op_a[31] != bus.op_b[31]) && (w_sub[31] != bus.op_a[31]);
      end
      AND:     w_alu_res = bus.op_a & bus.op_b;
      ORR:     w_alu_res = bus.op_a | bus.op_b;
      EOR:     w_alu_res = bus.op_a ^ bus.op_b;
      MOV:     w_alu_res = bus.op_b;
      default: w_alu_pass = 1'b1;
    endcase
    w_alu_flags = {w_alu_res[31], (w_alu_res == 32'd0), w_alu_c, w_alu_v};
    if (w_alu_pass) begin
      w_alu_flags = bus.flags_in;
    end
  end

  // Multiplicand walks left and multiplier walks right, so the low MUL_BITS
  // multiplier bits always gate the current partial products.
  for (genvar j = 0; j < MUL_BITS; j++) begin : g_pp
    assign w_pp[j] = mplier_q[j] ? (mcand_q << j) : 32'd0;
  end

  always_comb begin
    w_acc_next = acc_q;
    for (int j = 0; j < MUL_BITS; j++) begin
      w_acc_next = w_acc_next + w_pp[j];
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    sel_d     = sel_q;
    uop_d     = uop_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_sel_d = mul_sel_q;
    mul_cv_d  = mul_cv_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.uop == MUL) begin
            state_d   = MULT;
            mcand_d   = bus.op_a;
            mplier_d  = bus.op_b;
            acc_d     = 32'd0;
            cnt_d     = 5'd0;
            mul_sel_d = bus.sel_dest;
            mul_cv_d  = bus.flags_in[1:0];
          end else begin
            state_d  = DONE;
            result_d = w_alu_res;
            flags_d  = w_alu_flags;
            sel_d    = bus.sel_dest;
            uop_d    = bus.uop;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d    = w_acc_next;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == c_last_cnt) begin
          state_d  = DONE;
          cnt_d    = 5'd0;
          result_d = w_acc_next;
          flags_d  = {w_acc_next[31], (w_acc_next == 32'd0), mul_cv_q};
          sel_d    = mul_sel_q;
          uop_d    = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q   <= IDLE;
      result_q  <= 32'd0;
      flags_q   <= 4'd0;
      sel_q     <= 4'd0;
      uop_q     <= NOP;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      acc_q     <= 32'd0;
      cnt_q     <= 5'd0;
      mul_sel_q <= 4'd0;
      mul_cv_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      sel_q     <= sel_d;
      uop_q     <= uop_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mul_sel_q <= mul_sel_d;
      mul_cv_q  <= mul_cv_d;
    end
  end

  assign bus.result        = result_q;
  assign bus.flags_out     = flags_q;
  assign bus.sel_out       = sel_q;
  assign bus.uop_out       = uop_q;
  assign bus.done          = (state_q == DONE);
  assign bus.busy          = (state_q == MULT);
  assign bus.rf_not_enable = (state_q != DONE);

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// Scoreboard bench for execute_unit: one instance with MUL_BITS=1, one with MUL_BITS=4.
module tb_execute_unit;
  import Utilities::*;

  logic clock     = 1'b0;
  logic not_reset = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   failures  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  execute_unit_if bus1 ();
  execute_unit_if bus4 ();

  execute_unit #(.MUL_BITS(1)) dut1 (.clock(clock), .not_reset(not_reset), .bus(bus1));
  execute_unit #(.MUL_BITS(4)) dut4 (.clock(clock), .not_reset(not_reset), .bus(bus4));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  sel;
    Uop          uop;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitors: done is expected exactly on the cycle recorded at issue time.
  always @(negedge clock) begin
    logic ed;
    exp_t e;
    while (q1.size() > 0 && q1[0].cyc < cyc) void'(q1.pop_front());
    ed = (q1.size() > 0) && (q1[0].cyc == cyc);
    chk("u1.done", 32'(bus1.done), 32'(ed));
    chk("u1.rf_not_enable", 32'(bus1.rf_not_enable), 32'(!ed));
    if (ed) begin
      e = q1.pop_front();
      chk("u1.result", bus1.result, e.res);
      chk("u1.flags", 32'(bus1.flags_out), 32'(e.flg));
      chk("u1.sel_out", 32'(bus1.sel_out), 32'(e.sel));
      chk("u1.uop_out", 32'(bus1.uop_out), 32'(e.uop));
    end
  end

  always @(negedge clock) begin
    logic ed;
    exp_t e;
    while (q4.size() > 0 && q4[0].cyc < cyc) void'(q4.pop_front());
    ed = (q4.size() > 0) && (q4[0].cyc == cyc);
    chk("u4.done", 32'(bus4.done), 32'(ed));
    chk("u4.rf_not_enable", 32'(bus4.rf_not_enable), 32'(!ed));
    if (ed) begin
      e = q4.pop_front();
      chk("u4.result", bus4.result, e.res);
      chk("u4.flags", 32'(bus4.flags_out), 32'(e.flg));
      chk("u4.sel_out", 32'(bus4.sel_out), 32'(e.sel));
      chk("u4.uop_out", 32'(bus4.uop_out), 32'(e.uop));
    end
  end

  task automatic issue(input int d, input Uop u, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [3:0] fin,
                       input logic [31:0] res, input logic [3:0] flg, input int lat, input bit push);
    exp_t e;
    e.res = res;
    e.flg = flg;
    e.sel = sel;
    e.uop = u;
    e.cyc = cyc + lat;
    if (d == 4) begin
      bus4.start = 1'b1; bus4.uop = u; bus4.op_a = a; bus4.op_b = b;
      bus4.sel_dest = sel; bus4.flags_in = fin;
      if (push) q4.push_back(e);
    end else begin
      bus1.start = 1'b1; bus1.uop = u; bus1.op_a = a; bus1.op_b = b;
      bus1.sel_dest = sel; bus1.flags_in = fin;
      if (push) q1.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    bus1.start = 1'b0; bus1.uop = NOP; bus1.op_a = '0; bus1.op_b = '0;
    bus1.sel_dest = '0; bus1.flags_in = '0;
    bus4.start = 1'b0; bus4.uop = NOP; bus4.op_a = '0; bus4.op_b = '0;
    bus4.sel_dest = '0; bus4.flags_in = '0;
    repeat (3) @(negedge clock);

    chk("rst.result", bus1.result, 32'd0);
    chk("rst.flags", 32'(bus1.flags_out), 32'd0);
    chk("rst.sel_out", 32'(bus1.sel_out), 32'd0);
    chk("rst.uop_out", 32'(bus1.uop_out), 32'(NOP));
    chk("rst.busy", 32'(bus1.busy), 32'd0);
    chk("rst.busy4", 32'(bus4.busy), 32'd0);
    not_reset = 1'b1;
    idle(2);

    // Single-cycle ops, back-to-back
    issue(1, ADD, 32'hFFFFFFFF, 32'h1, 4'd1, 4'b0000, 32'h0, 4'b0110, 1, 1);
    issue(1, SUB, 32'h80000000, 32'h1, 4'd2, 4'b0000, 32'h7FFFFFFF, 4'b0011, 1, 1);
    issue(1, CMP, 32'd5, 32'd7, 4'd3, 4'b0000, 32'hFFFFFFFE, 4'b1000, 1, 1);
    issue(1, AND, 32'hF0F0FFFF, 32'h0FF0000F, 4'd4, 4'b0011, 32'h00F0000F, 4'b0011, 1, 1);
    issue(1, ORR, 32'h0, 32'h0, 4'd5, 4'b0101, 32'h0, 4'b0101, 1, 1);
    issue(1, EOR, 32'h80000000, 32'h1, 4'd6, 4'b0010, 32'h80000001, 4'b1010, 1, 1);
    issue(1, MOV, 32'h12345678, 32'h0, 4'd7, 4'b1001, 32'h0, 4'b0101, 1, 1);
    issue(1, NOP, 32'h5, 32'h1234, 4'd8, 4'b1100, 32'h1234, 4'b1100, 1, 1);
    issue(1, STR, 32'h5, 32'hAB, 4'd9, 4'b0001, 32'hAB, 4'b0001, 1, 1);
    idle(3);

    // Four consecutive ADDs
    issue(1, ADD, 32'd1, 32'd2, 4'd4, 4'b0000, 32'd3, 4'b0000, 1, 1);
    issue(1, ADD, 32'h7FFFFFFF, 32'h1, 4'd5, 4'b0000, 32'h80000000, 4'b1001, 1, 1);
    issue(1, ADD, 32'h80000000, 32'h80000000, 4'd6, 4'b0000, 32'h0, 4'b0111, 1, 1);
    issue(1, ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 4'b0000, 32'hFFFFFFFE, 4'b1010, 1, 1);
    idle(3);

    // MUL accepted from DONE; an ADD while busy must be ignored
    issue(1, ADD, 32'h10, 32'h20, 4'd8, 4'b0000, 32'h30, 4'b0000, 1, 1);
    issue(1, MUL, 32'h10000, 32'h10001, 4'd9, 4'b0011, 32'h00010000, 4'b0011, 33, 1);
    chk("mul.busy_start", 32'(bus1.busy), 32'd1);
    idle(3);
    issue(1, ADD, 32'd1, 32'd1, 4'd15, 4'b0000, 32'd0, 4'b0000, 0, 0);
    chk("mul.busy_ignored", 32'(bus1.busy), 32'd1);
    idle(27);
    chk("mul.busy_last", 32'(bus1.busy), 32'd1);
    idle(1);
    chk("mul.busy_done", 32'(bus1.busy), 32'd0);
    issue(1, ADD, 32'h100, 32'h200, 4'd10, 4'b0000, 32'h300, 4'b0000, 1, 1);
    issue(1, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd11, 4'b1101, 32'h1, 4'b0001, 33, 1);
    idle(32);
    issue(1, MUL, 32'd3, 32'h80000000, 4'd12, 4'b0010, 32'h80000000, 4'b1010, 33, 1);
    idle(34);

    // MUL_BITS=4 instance
    issue(4, MUL, 32'h10000, 32'h10001, 4'd2, 4'b0001, 32'h00010000, 4'b0001, 9, 1);
    chk("mul4.busy", 32'(bus4.busy), 32'd1);
    idle(8);
    issue(4, MUL, 32'hFFFF, 32'hFFFF, 4'd3, 4'b0000, 32'hFFFE0001, 4'b1000, 9, 1);
    idle(10);

    // Reset in the middle of a MUL: no done may ever follow
    issue(1, MUL, 32'h10000, 32'h10001, 4'd1, 4'b0000, 32'd0, 4'b0000, 0, 0);
    idle(8);
    #2 not_reset = 1'b0;
    #1;
    chk("mrst.busy", 32'(bus1.busy), 32'd0);
    chk("mrst.done", 32'(bus1.done), 32'd0);
    chk("mrst.rf_not_enable", 32'(bus1.rf_not_enable), 32'd1);
    chk("mrst.result", bus1.result, 32'd0);
    @(negedge clock);
    not_reset = 1'b1;
    idle(40);
    issue(1, ADD, 32'd2, 32'd3, 4'd6, 4'b0000, 32'd5, 4'b0000, 1, 1);
    idle(2);

    for (int i = 0; i < 50 && (q1.size() + q4.size()) > 0; i++) @(negedge clock);
    chk("drain", 32'(q1.size() + q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
